// File: rtl/gpio_apb_master.sv
// Single-outstanding APB requester that bridges a valid/ready command/response port to a GPIO completer.
// Optional ACCESS-phase timeout abort is enabled by defining GPIO_APB_TIMEOUT_EN.
module gpio_apb_master #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
    $error("gpio_apb_master: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("gpio_apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;
  logic   accept;
  logic   complete;
  logic   abort;

  // The reset term keeps cmd_ready low for the whole time rst is asserted.
  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && (state == IDLE);
  assign complete  = (state == ACCESS) && pready;

`ifdef GPIO_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // pready takes priority over the limit: abort only fires when the last allowed cycle also lacks pready.
  assign abort = (state == ACCESS) && !pready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait-state counter: cleared on SETUP entry, saturating while ACCESS stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready && (wait_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Timeout flag: set by an abort, cleared by any normal completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_timeout <= 1'b0;
    end else if (complete) begin
      rsp_timeout <= 1'b0;
    end else if (abort) begin
      rsp_timeout <= 1'b1;
    end else begin
      rsp_timeout <= rsp_timeout;
    end
  end
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SETUP;
        else        next_state = IDLE;
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (complete || abort) next_state = RESP;
        else                   next_state = ACCESS;
      end
      RESP: begin
        if (rsp_ready) next_state = IDLE;
        else           next_state = RESP;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Bus and handshake strobes are flops loaded from the next state, so no input reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      psel      <= (next_state == SETUP) || (next_state == ACCESS);
      penable   <= (next_state == ACCESS);
      rsp_valid <= (next_state == RESP);
    end
  end

  // Command capture; held stable until the next accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
      pstrb  <= cmd_write ? cmd_strb : {STRB_WIDTH{1'b0}};
    end else begin
      pwrite <= pwrite;
      paddr  <= paddr;
      pwdata <= pwdata;
      pstrb  <= pstrb;
    end
  end

  // Response capture at the end of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (complete) begin
      rsp_rdata <= pwrite ? {DATA_WIDTH{1'b0}} : prdata;
      rsp_err   <= pslverr;
    end else if (abort) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else begin
      rsp_rdata <= rsp_rdata;
      rsp_err   <= rsp_err;
    end
  end

endmodule

// File: tb/tb_gpio_apb_master.sv
// Directed self-checking bench for gpio_apb_master with a hand-driven APB completer.
// Build with GPIO_APB_TIMEOUT_EN defined to exercise the timeout abort path.
module tb_gpio_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [11:0] paddr;
  logic        pwrite, psel, penable;
  logic [3:0]  pstrb;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;

  gpio_apb_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one transfer starting at a negedge; completer inserts 'waits' wait states, host stalls 'hold' cycles.
  task automatic run_txn(input string name, input logic wr, input logic [11:0] a,
                         input logic [31:0] wd, input logic [3:0] st, input logic [31:0] rd,
                         input int waits, input logic err, input int hold,
                         output int lat, output int acc, output logic [31:0] rdata,
                         output logic rerr, output logic rto);
    int ps;
    int bad;
    int hbad;
    ps = 0; bad = 0; hbad = 0; acc = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = st;
    prdata = rd; pslverr = err; pready = 1'b0;
    check({name, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    check({name, ".setup_psel"}, 32'(psel), 32'd1);
    check({name, ".setup_penable"}, 32'(penable), 32'd0);
    check({name, ".pstrb"}, 32'(pstrb), wr ? 32'(st) : 32'd0);
    check({name, ".pwrite"}, 32'(pwrite), 32'(wr));
    check({name, ".busy_ready"}, 32'(cmd_ready), 32'd0);
    while (!rsp_valid && lat < 2000) begin
      if (penable) begin
        acc++;
        if (paddr !== a || pwdata !== wd || pwrite !== wr || !psel) bad++;
        pready = (acc > waits);
      end
      if (psel) ps++;
      @(negedge clk);
      lat++;
    end
    pready = 1'b0;
    check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, ".access_stable"}, 32'(bad), 32'd0);
    check({name, ".psel_span"}, 32'(ps), 32'(acc + 1));
    check({name, ".resp_psel"}, 32'(psel), 32'd0);
    rdata = rsp_rdata; rerr = rsp_err; rto = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      if (!rsp_valid || cmd_ready || rsp_rdata !== rdata || rsp_err !== rerr) hbad++;
      @(negedge clk);
    end
    check({name, ".hold_stable"}, 32'(hbad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, ".post_valid"}, 32'(rsp_valid), 32'd0);
    check({name, ".post_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, acc;
    logic [31:0] rdata;
    logic rerr, rto;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h000;
    cmd_wdata = 32'h0; cmd_strb = 4'h0; rsp_ready = 1'b0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset.cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset.psel", 32'(psel), 32'd0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.paddr", 32'(paddr), 32'd0);
    rst = 1'b0;
    #1;
    check("release.cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    run_txn("wr0", 1'b1, 12'h000, 32'h12345678, 4'hF, 32'hDEADBEEF, 0, 1'b0, 0, lat, acc, rdata, rerr, rto);
    check("wr0.latency", 32'(lat), 32'd3);
    check("wr0.access", 32'(acc), 32'd1);
    check("wr0.rdata", rdata, 32'h0);
    check("wr0.err", 32'(rerr), 32'd0);
    check("wr0.timeout", 32'(rto), 32'd0);

    run_txn("rd204", 1'b0, 12'h204, 32'h0, 4'hF, 32'h90ABCDEF, 3, 1'b0, 0, lat, acc, rdata, rerr, rto);
    check("rd204.latency", 32'(lat), 32'd6);
    check("rd204.access", 32'(acc), 32'd4);
    check("rd204.rdata", rdata, 32'h90ABCDEF);
    check("rd204.err", 32'(rerr), 32'd0);

    run_txn("rderr", 1'b0, 12'h010, 32'h0, 4'h0, 32'h5A5A0001, 1, 1'b1, 5, lat, acc, rdata, rerr, rto);
    check("rderr.latency", 32'(lat), 32'd4);
    check("rderr.rdata", rdata, 32'h5A5A0001);
    check("rderr.err", 32'(rerr), 32'd1);
    check("rderr.timeout", 32'(rto), 32'd0);

    run_txn("wrstrb", 1'b1, 12'hFFC, 32'hA5A5C3C3, 4'h5, 32'hFFFFFFFF, 2, 1'b0, 0, lat, acc, rdata, rerr, rto);
    check("wrstrb.latency", 32'(lat), 32'd5);
    check("wrstrb.rdata", rdata, 32'h0);
    check("wrstrb.err", 32'(rerr), 32'd0);

`ifdef GPIO_APB_TIMEOUT_EN
    run_txn("tmo", 1'b0, 12'h100, 32'h0, 4'h0, 32'h11112222, 1000, 1'b0, 0, lat, acc, rdata, rerr, rto);
    check("tmo.access", 32'(acc), 32'd4);
    check("tmo.latency", 32'(lat), 32'd6);
    check("tmo.rdata", rdata, 32'h0);
    check("tmo.err", 32'(rerr), 32'd1);
    check("tmo.timeout", 32'(rto), 32'd1);
`else
    run_txn("hang", 1'b0, 12'h100, 32'h0, 4'h0, 32'h11112222, 1000, 1'b0, 0, lat, acc, rdata, rerr, rto);
    check("hang.access", 32'(acc), 32'd1001);
    check("hang.rdata", rdata, 32'h11112222);
    check("hang.timeout", 32'(rto), 32'd0);
`endif

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040; pready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rstmid.in_access", 32'(penable), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid.psel", 32'(psel), 32'd0);
    check("rstmid.penable", 32'(penable), 32'd0);
    check("rstmid.cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid.release_ready", 32'(cmd_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (rsp_valid || psel) seen++;
      end
      check("rstmid.no_response", 32'(seen), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
